regwb_arbiter: RTL
==================

REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  clock, posedge-active; rst  input  1  reset, asynchronous, active-high.
REQ-002 The requester 0 (ALU write-back) ports SHALL be: req0_valid  input  1; req0_addr  input  5  destination register; req0_data  input  32; req0_ready  output  1.
REQ-003 The requester 1 (memory-load write-back) ports SHALL be: req1_valid  input  1; req1_addr  input  5; req1_data  input  32; req1_ready  output  1.
REQ-004 The reservation port SHALL be: rsv_valid  input  1  issue claims a destination; rsv_addr  input  5.
REQ-005 The hazard query ports SHALL be: q1_addr  input  5  rs; q2_addr  input  5  rt; q1_busy  output  1; q2_busy  output  1.
REQ-006 The register-file write port SHALL be: a3  output  5; writedata  output  32; regwe  output  1; all three registered.
REQ-007 The error output SHALL be: stray_err  output  1  sticky, set on a write-back to an unreserved register.

Function
REQ-008 Handshake: a transfer on requester N SHALL occur when reqN_valid && reqN_ready are both high at a clk posedge; reqN_ready SHALL be combinational and may depend on reqN_valid.
REQ-009 Arbitration: at most one of req0_ready/req1_ready SHALL be high per cycle; a lone valid requester SHALL be granted; when both are valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-010 The round-robin pointer SHALL update only on a transfer, pointing to the other requester.
REQ-011 Latency: on a transfer, a3/writedata SHALL take the granted addr/data at that posedge, and regwe SHALL go 1 for exactly one cycle, or stay 0 if addr==0.
REQ-012 Without a transfer, regwe SHALL be 0 and a3/writedata SHALL hold their previous values.
REQ-013 Outputs change on posedge only, so they SHALL be stable for the register file's negedge write in the same cycle.
REQ-014 Scoreboard: pending[31:1] SHALL be one bit per register; register 0 is never pending.
REQ-015 rsv_valid with rsv_addr!=0 SHALL set pending[rsv_addr] at the posedge.
REQ-016 A transfer with addr!=0 SHALL clear pending[addr] at the same posedge that loads the output register.
REQ-017 When a set and a clear target the same address in one cycle, set SHALL win and the bit SHALL stay 1.
REQ-018 qN_busy SHALL equal pending[qN_addr], combinationally, and SHALL be 0 for qN_addr==0.
REQ-019 A transfer with addr!=0 whose pending bit is 0 (and not being set that cycle) SHALL set stray_err; the write still proceeds.
REQ-020 A reservation to an already-pending address SHALL leave the bit at 1 and raise no error.

Reset
REQ-021 While rst is high: regwe=0, a3=0, writedata=0, pending all 0, stray_err=0, and the round-robin pointer favours requester 0.
REQ-022 Reset SHALL take effect immediately and asynchronously; a request pending at reset assertion SHALL be dropped, with no write issued.
REQ-023 Ready outputs SHALL be 0 while rst is high.

Structure
REQ-024 A shared package regwb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the requester index enum (REQ_ALU=0, REQ_MEM=1).
REQ-025 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]); the scoreboard and output register stay in regwb_arbiter.

Verification
REQ-026 rsv 8; then req0 addr 8, data 0x11111111 alone -> req0_ready=1; next cycle a3=8, writedata=0x11111111, regwe=1 for one cycle; q1_addr=8 busy 1 before, 0 after.
REQ-027 Both valid for 4 cycles after reset, addrs 3/4 reserved -> grants alternate 0,1,0,1 and regwe is high for 4 consecutive cycles.
REQ-028 req1 addr 0, data 0xDEADBEEF -> transfer accepted, regwe stays 0, stray_err stays 0.
REQ-029 rsv 5 and req0 write to 5 in the same cycle (5 already pending) -> write issued and pending[5] remains 1.
REQ-030 Write to unreserved register 9 -> stray_err=1 and stays set until rst.
REQ-031 Assert rst mid-cycle with both requests valid and pending[2]=1 -> immediately regwe=0, readies 0, q busy 0, and the next grant after release goes to requester 0.

Source files
------------

// File: rtl/regwb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwb_pkg
// Description : Shared widths, types and helpers for the register write-back
//               arbiter and its two-way round-robin sub-arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regwb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // Requester index; REQ_ALU is the favoured side after reset.
  typedef enum logic [0:0] {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

  // The requester that was not just served.
  function automatic req_idx_e other_req(input req_idx_e idx);
    return (idx == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regwb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter_if
// Description : Bundle of requester handshakes, reservation/query ports and
//               register-file write port around the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regwb_arbiter_if;
  import regwb_pkg::*;

  // Requester 0: ALU write-back
  logic      req0_valid;
  reg_addr_t req0_addr;
  reg_data_t req0_data;
  logic      req0_ready;

  // Requester 1: memory-load write-back
  logic      req1_valid;
  reg_addr_t req1_addr;
  reg_data_t req1_data;
  logic      req1_ready;

  // Issue-side destination reservation
  logic      rsv_valid;
  reg_addr_t rsv_addr;

  // Hazard queries for rs / rt
  reg_addr_t q1_addr;
  reg_addr_t q2_addr;
  logic      q1_busy;
  logic      q2_busy;

  // Register-file write port and error flag
  reg_addr_t a3;
  reg_data_t writedata;
  logic      regwe;
  logic      stray_err;

  // Side that drives requests, reservations and queries
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output rsv_valid, rsv_addr,
    output q1_addr, q2_addr,
    input  q1_busy, q2_busy,
    input  a3, writedata, regwe, stray_err
  );

  // The arbiter itself
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  rsv_valid, rsv_addr,
    input  q1_addr, q2_addr,
    output q1_busy, q2_busy,
    output a3, writedata, regwe, stray_err
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone request always wins; on a
//               tie the side not served most recently wins. The priority
//               pointer moves only when the caller reports a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import regwb_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req,
  input  wire logic       advance,
  output logic      [1:0] gnt
);

  req_idx_e r_favour;
  req_idx_e w_favour_next;

  // Priority pointer; favours the ALU side out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_favour <= REQ_ALU;
    end else begin
      r_favour <= w_favour_next;
    end
  end

  // After a transfer, point at the side that was not just served
  always_comb begin
    w_favour_next = r_favour;
    if (advance && (gnt != 2'b00)) begin
      w_favour_next = other_req(gnt[1] ? REQ_MEM : REQ_ALU);
    end
  end

  // One-hot grant; ties resolved by the pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_favour == REQ_ALU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwb_arbiter
// Description : Arbitrates ALU and memory write-backs onto a single register
//               file write port, tracks in-flight destinations in a pending
//               scoreboard for hazard queries, and flags write-backs to
//               registers that were never reserved.
// Revision    : 1.0 - initial release
// ============================================================================
module regwb_arbiter
  import regwb_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  regwb_arbiter_if.slave bus
);

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_xfer;
  reg_addr_t           w_addr;
  reg_data_t           w_data;
  logic                w_stray;
  logic                w_rsv_set;
  logic [NUM_REGS-1:0] w_pending_next;

  logic [NUM_REGS-1:0] r_pending;
  reg_addr_t           r_a3;
  reg_data_t           r_writedata;
  logic                r_regwe;
  logic                r_stray_err;

  assign w_req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_xfer),
    .gnt     (w_gnt)
  );

  // Readies are masked during reset so nothing can be accepted then
  assign bus.req0_ready = w_gnt[0] & ~rst;
  assign bus.req1_ready = w_gnt[1] & ~rst;

  assign w_xfer = (bus.req0_valid & bus.req0_ready) |
                  (bus.req1_valid & bus.req1_ready);

  assign w_rsv_set = bus.rsv_valid && (bus.rsv_addr != '0);

  // Select the winning requester's destination and payload
  always_comb begin
    w_addr = bus.req0_addr;
    w_data = bus.req0_data;
    if (bus.req1_ready) begin
      w_addr = bus.req1_addr;
      w_data = bus.req1_data;
    end
  end

  // A write-back is stray if its register is neither pending nor being claimed now
  always_comb begin
    w_stray = 1'b0;
    if (w_xfer && (w_addr != '0) && !r_pending[w_addr] &&
        !(w_rsv_set && (bus.rsv_addr == w_addr))) begin
      w_stray = 1'b1;
    end
  end

  // Scoreboard update: clear on write-back, then set on reservation so a
  // same-cycle set always wins; register 0 is never pending
  always_comb begin
    w_pending_next = r_pending;
    if (w_xfer && (w_addr != '0)) begin
      w_pending_next[w_addr] = 1'b0;
    end
    if (w_rsv_set) begin
      w_pending_next[bus.rsv_addr] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  // Pending scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Register-file write port: load on transfer, single-cycle write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a3        <= '0;
      r_writedata <= '0;
      r_regwe     <= 1'b0;
    end else begin
      r_regwe <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_a3        <= w_addr;
        r_writedata <= w_data;
      end
    end
  end

  // Sticky stray-write flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stray_err <= 1'b0;
    end else if (w_stray) begin
      r_stray_err <= 1'b1;
    end
  end

  assign bus.a3        = r_a3;
  assign bus.writedata = r_writedata;
  assign bus.regwe     = r_regwe;
  assign bus.stray_err = r_stray_err;

  // Hazard queries read the scoreboard directly; bit 0 is held at 0
  assign bus.q1_busy = r_pending[bus.q1_addr];
  assign bus.q2_busy = r_pending[bus.q2_addr];

endmodule
`default_nettype wire
